// File: rtl/r2r_dac_pkg.sv
// Shared types and constants for the R2R DAC waveform sequencer.
// Mode encoding, LFSR seed/taps, divider default and LFSR step helper.
package r2r_dac_pkg;

  typedef enum logic [1:0] {
    MODE_EXT = 2'd0,
    MODE_SAW = 2'd1,
    MODE_TRI = 2'd2,
    MODE_SQR = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DIV_RESET_DEF = 1000;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) begin
      n = n ^ LFSR_TAPS;
    end
    return n;
  endfunction

endpackage

// File: rtl/r2r_clk_divider.sv
// Loadable sample-rate divider; tick period is div_reg+1 cycles.
// Ports: clk, rst_n, ena, load_div, load_data[DIV_W] -> tick (combinational).
module r2r_clk_divider
  import r2r_dac_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = DIV_RESET_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load_div,
  input  logic [DIV_W-1:0] load_data,
  output logic             tick
);

  localparam logic [DIV_W-1:0] RST_VAL = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             w_zero;

  assign w_zero = (r_cnt == '0);

  // A load in the same cycle swallows the tick
  assign tick = ena & ~load_div & w_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= RST_VAL;
      r_cnt <= RST_VAL;
    end else if (load_div) begin
      r_div <= load_data;
      r_cnt <= load_data;
    end else if (ena) begin
      if (w_zero) begin
        r_cnt <= r_div;
      end else begin
        r_cnt <= r_cnt - ONE;
      end
    end
  end

endmodule

// File: rtl/r2r_dac_sequencer.sv
// Waveform sequencer (EXT/SAW/TRI/SQR) driving an N-bit R2R DAC.
// Ports: clk, rst_n, ena, mode[2], ext_data, step, load_div, load_data
//        -> dac_out, cnt_zero, phase_wrap.
// Build option: define R2R_DAC_NOISE_EN to turn mode 3 into LFSR noise.
module r2r_dac_sequencer
  import r2r_dac_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = DIV_RESET_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] ext_data,
  input  logic [DATA_W-1:0] step,
  input  logic              load_div,
  input  logic [DIV_W-1:0]  load_data,
  output logic [DATA_W-1:0] dac_out,
  output logic              cnt_zero,
  output logic              phase_wrap
);

  localparam logic [DATA_W-1:0] MAX  = '1;
  localparam logic [DATA_W:0]   MAXW = {1'b0, MAX};

  logic              w_tick;
  mode_e             w_mode_in;
  logic [DATA_W:0]   w_sum;

  logic [DATA_W-1:0] r_phase;
  dir_e              r_dir;
  mode_e             r_mode;
  logic [DATA_W-1:0] r_dac;
  logic              r_cz;
  logic              r_wrap;

  logic [DATA_W-1:0] w_phase_n;
  dir_e              w_dir_n;
  mode_e             w_mode_n;
  logic [DATA_W-1:0] w_dac_n;
  logic              w_wrap_n;

`ifdef R2R_DAC_NOISE_EN
  logic [15:0]       r_lfsr;
  logic [15:0]       w_lfsr_n;
`endif

  r2r_clk_divider #(
    .DIV_W     (DIV_W),
    .DIV_RESET (DIV_RESET)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .load_div  (load_div),
    .load_data (load_data),
    .tick      (w_tick)
  );

  assign w_mode_in = mode_e'(mode);

  // One guard bit: carry for SAW, overshoot test for TRI
  assign w_sum = {1'b0, r_phase} + {1'b0, step};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_dir   <= DIR_UP;
      r_mode  <= MODE_EXT;
      r_dac   <= '0;
      r_cz    <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_phase <= w_phase_n;
      r_dir   <= w_dir_n;
      r_mode  <= w_mode_n;
      r_dac   <= w_dac_n;
      r_cz    <= w_tick;
      r_wrap  <= w_wrap_n;
    end
  end

`ifdef R2R_DAC_NOISE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= w_lfsr_n;
    end
  end
`endif

  always_comb begin
    w_phase_n = r_phase;
    w_dir_n   = r_dir;
    w_mode_n  = r_mode;
    w_dac_n   = r_dac;
    w_wrap_n  = 1'b0;
`ifdef R2R_DAC_NOISE_EN
    w_lfsr_n  = r_lfsr;
`endif

    if (ena) begin
      if (w_mode_in != r_mode) begin
        // Mode entry restarts the waveform; no advance this cycle
        w_mode_n  = w_mode_in;
        w_phase_n = '0;
        w_dir_n   = DIR_UP;
        w_dac_n   = (w_mode_in == MODE_EXT) ? ext_data : '0;
`ifdef R2R_DAC_NOISE_EN
        w_lfsr_n  = LFSR_SEED;
`endif
      end else begin
        unique case (1'b1)
          (r_mode == MODE_EXT): begin
            w_dac_n = ext_data;
          end
          (r_mode == MODE_SAW): begin
            if (w_tick) begin
              w_phase_n = w_sum[DATA_W-1:0];
              w_dac_n   = w_sum[DATA_W-1:0];
              w_wrap_n  = w_sum[DATA_W];
            end
          end
          (r_mode == MODE_TRI): begin
            if (w_tick) begin
              if (r_dir == DIR_UP) begin
                if (w_sum >= MAXW) begin
                  w_phase_n = MAX;
                  w_dir_n   = DIR_DN;
                end else begin
                  w_phase_n = w_sum[DATA_W-1:0];
                end
              end else begin
                if (r_phase <= step) begin
                  w_phase_n = '0;
                  w_dir_n   = DIR_UP;
                  w_wrap_n  = 1'b1;
                end else begin
                  w_phase_n = r_phase - step;
                end
              end
              w_dac_n = w_phase_n;
            end
          end
          (r_mode == MODE_SQR): begin
            if (w_tick) begin
`ifdef R2R_DAC_NOISE_EN
              w_lfsr_n = lfsr_next(r_lfsr);
              w_dac_n  = w_lfsr_n[DATA_W-1:0];
`else
              w_phase_n = w_sum[DATA_W-1:0];
              w_dac_n   = {DATA_W{w_sum[DATA_W-1]}};
`endif
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign dac_out    = r_dac;
  assign cnt_zero   = r_cz;
  assign phase_wrap = r_wrap;

endmodule

// File: tb/tb_r2r_dac_sequencer.sv
// Directed scoreboard bench for r2r_dac_sequencer (DATA_W=8, DIV_RESET=4).
// Define R2R_DAC_NOISE_EN to exercise the LFSR mode instead of SQR.
module tb_r2r_dac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [1:0]  mode;
  logic [7:0]  ext_data;
  logic [7:0]  step;
  logic        load_div;
  logic [15:0] load_data;
  logic [7:0]  dac_out;
  logic        cnt_zero;
  logic        phase_wrap;

  r2r_dac_sequencer #(
    .DATA_W    (8),
    .DIV_W     (16),
    .DIV_RESET (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .mode       (mode),
    .ext_data   (ext_data),
    .step       (step),
    .load_div   (load_div),
    .load_data  (load_data),
    .dac_out    (dac_out),
    .cnt_zero   (cnt_zero),
    .phase_wrap (phase_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    bit         cz;
    bit         wr;
    logic [7:0] dac;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input string tag, input bit cz, input bit wr,
                      input logic [7:0] d);
    exp_t e;
    e.tag = tag;
    e.cz  = cz;
    e.wr  = wr;
    e.dac = d;
    q.push_back(e);
  endtask

  // One expectation per clock cycle
  task automatic drain_cycles();
    exp_t e;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      chk({e.tag, " cz"}, 32'(cnt_zero), 32'(e.cz));
      chk({e.tag, " wrap"}, 32'(phase_wrap), 32'(e.wr));
      chk({e.tag, " dac"}, 32'(dac_out), 32'(e.dac));
    end
  endtask

  // One expectation per sample tick, bounded wait
  task automatic drain_ticks();
    exp_t e;
    int   n;
    while (q.size() > 0) begin
      e = q.pop_front();
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!cnt_zero && n < 20);
      chk({e.tag, " tick"}, 32'(cnt_zero), 32'd1);
      chk({e.tag, " wrap"}, 32'(phase_wrap), 32'(e.wr));
      chk({e.tag, " dac"}, 32'(dac_out), 32'(e.dac));
    end
  endtask

  function automatic logic [15:0] model_lfsr(input logic [15:0] s);
    logic fb;
    logic [15:0] r;
    fb = s[0];
    r  = s >> 1;
    if (fb) r = r ^ 16'hB400;
    return r;
  endfunction

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    mode      = 2'd0;
    ext_data  = 8'h00;
    step      = 8'd0;
    load_div  = 1'b0;
    load_data = 16'd0;

    @(negedge clk);
    @(negedge clk);
    chk("rst dac", 32'(dac_out), 32'd0);
    chk("rst cz", 32'(cnt_zero), 32'd0);
    chk("rst wrap", 32'(phase_wrap), 32'd0);
    rst_n = 1'b1;

    // Idle in EXT with ext_data=0: tick every 5 cycles
    for (int i = 1; i <= 15; i++) begin
      push($sformatf("idle %0d", i), (i % 5) == 0, 1'b0, 8'h00);
    end
    drain_cycles();

    // SAW step=1 full cycle
    mode = 2'd1;
    step = 8'd1;
    for (int k = 1; k <= 256; k++) begin
      push($sformatf("saw1 %0d", k), 1'b1, k == 256, 8'(k % 256));
    end
    drain_ticks();

    // SAW step=3 with div=0 through 252 -> 255 -> 2
    step      = 8'd3;
    load_div  = 1'b1;
    load_data = 16'd0;
    @(negedge clk);
    chk("load0 supp", 32'(cnt_zero), 32'd0);
    load_div = 1'b0;
    for (int k = 1; k <= 86; k++) begin
      push($sformatf("saw3 %0d", k), 1'b1, k == 86, 8'((3 * k) % 256));
    end
    drain_ticks();

    // TRI step=100; entry tick holds at 0
    mode = 2'd2;
    step = 8'd100;
    push("tri entry", 1'b1, 1'b0, 8'd0);
    push("tri 100", 1'b1, 1'b0, 8'd100);
    push("tri 200", 1'b1, 1'b0, 8'd200);
    push("tri 255", 1'b1, 1'b0, 8'd255);
    push("tri 155", 1'b1, 1'b0, 8'd155);
    push("tri 55", 1'b1, 1'b0, 8'd55);
    push("tri 0", 1'b1, 1'b1, 8'd0);
    push("tri up", 1'b1, 1'b0, 8'd100);
    drain_ticks();

    // EXT passthrough, then back to SAW
    mode     = 2'd0;
    ext_data = 8'hA5;
    push("ext a5", 1'b1, 1'b0, 8'hA5);
    drain_cycles();
    ext_data = 8'h3C;
    push("ext 3c", 1'b1, 1'b0, 8'h3C);
    drain_cycles();
    mode = 2'd1;
    step = 8'd5;
    push("saw entry", 1'b1, 1'b0, 8'h00);
    drain_cycles();
    push("saw 5", 1'b1, 1'b0, 8'h05);
    drain_cycles();

    // Load coincident with a tick, then period 3
    load_div  = 1'b1;
    load_data = 16'd2;
    push("ld tick", 1'b0, 1'b0, 8'h05);
    drain_cycles();
    load_div = 1'b0;
    push("p3 a", 1'b0, 1'b0, 8'h05);
    push("p3 b", 1'b0, 1'b0, 8'h05);
    push("p3 c", 1'b1, 1'b0, 8'h0A);
    push("p3 d", 1'b0, 1'b0, 8'h0A);
    push("p3 e", 1'b0, 1'b0, 8'h0A);
    push("p3 f", 1'b1, 1'b0, 8'h0F);
    drain_cycles();

    // Freeze
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push($sformatf("frz %0d", i), 1'b0, 1'b0, 8'h0F);
    end
    drain_cycles();
    ena = 1'b1;
    push("thaw a", 1'b0, 1'b0, 8'h0F);
    push("thaw b", 1'b0, 1'b0, 8'h0F);
    push("thaw c", 1'b1, 1'b0, 8'h14);
    drain_cycles();

    mode = 2'd3;
    step = 8'd64;
`ifdef R2R_DAC_NOISE_EN
    begin
      logic [15:0] s;
      s = 16'hACE1;
      for (int k = 1; k <= 4; k++) begin
        s = model_lfsr(s);
        push($sformatf("noise %0d", k), 1'b1, 1'b0, s[7:0]);
      end
    end
`else
    push("sqr 64", 1'b1, 1'b0, 8'h00);
    push("sqr 128", 1'b1, 1'b0, 8'hFF);
    push("sqr 192", 1'b1, 1'b0, 8'hFF);
`endif
    drain_ticks();

    // Asynchronous reset during TRI descent
    mode = 2'd2;
    step = 8'd100;
    push("tri2 100", 1'b1, 1'b0, 8'd100);
    push("tri2 200", 1'b1, 1'b0, 8'd200);
    push("tri2 255", 1'b1, 1'b0, 8'd255);
    push("tri2 155", 1'b1, 1'b0, 8'd155);
    drain_ticks();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async dac", 32'(dac_out), 32'd0);
    chk("async cz", 32'(cnt_zero), 32'd0);
    chk("async wrap", 32'(phase_wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push("rst2 1", 1'b0, 1'b0, 8'd0);
    push("rst2 2", 1'b0, 1'b0, 8'd0);
    push("rst2 3", 1'b0, 1'b0, 8'd0);
    push("rst2 4", 1'b0, 1'b0, 8'd0);
    push("rst2 5", 1'b1, 1'b0, 8'd100);
    drain_cycles();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
